rv_fetch: RTL and testbench
===========================

Name: rv_fetch

Overview:
- Instruction fetch stage that sits directly upstream of rv_instr_mem.
- Owns the program counter (PC) and drives the word-indexed imem address. It captures the combinational instruction that comes back in the same cycle into a 2-entry fetch buffer.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Handles branch redirects, flushes, fetch enable, and alignment/range faults.

Parameters:
RESET_PC, 32'h0000_0000, byte address the PC loads on reset; must be 4-byte aligned.
IMEM_DEPTH, 1024, number of 32-bit words in instruction memory; word indices at or above this fault.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
fetch_en_i  input  1  1 = fetch allowed; 0 = stop issuing new fetches.
imem_addr_o  output  32  word index into imem, equal to {2'b00, pc_q[31:2]}; combinational from pc_q.
imem_instr_i  input  32  instruction read from imem at imem_addr_o; valid in the same cycle.
redirect_i  input  1  branch/jump taken; flush the buffer and load the new PC.
redirect_pc_i  input  32  byte address of the redirect target.
if_valid_o  output  1  buffer head is valid.
if_ready_i  input  1  decode accepts the head.
if_pc_o  output  32  byte PC of the head entry.
if_instr_o  output  32  instruction of the head entry.
fault_o  output  1  fetch is halted on a fault.
fault_pc_o  output  32  PC that caused the fault.

Behaviour:
Reset values:
- pc_q = RESET_PC; state = IDLE; buffer count = 0.
- if_valid_o = 0; fault_o = 0; fault_pc_o = 0.
- Buffer data is don't-care.
- Reset asserted mid-operation discards all buffered entries immediately.

FSM states:
- IDLE -> RUN when fetch_en_i = 1.
- RUN -> IDLE when fetch_en_i = 0.
- RUN -> FAULT when the fault check below fires.
- FAULT -> RUN on redirect_i = 1, regardless of fetch_en_i.
  - If fetch_en_i = 0 at that point, the FSM leaves RUN for IDLE on the next cycle.
- FAULT is otherwise sticky.
- fault_o = 1 exactly while in FAULT.

Fault check (evaluated in RUN):
- Fault condition: pc_q[1:0] != 0, or pc_q[31:2] >= IMEM_DEPTH.
- On fault: no push; FAULT entered next cycle; fault_pc_o <= pc_q.
- fault_pc_o holds until the next fault.

Push:
- Push when state == RUN, fetch_en_i = 1, no fault, count < 2 (registered count, pre-pop), and redirect_i = 0.
- Push writes {pc_q, imem_instr_i} to the tail, and pc_q <= pc_q + 4 (wraps modulo 2^32).
- No push while full, even if a pop occurs in the same cycle. This keeps if_ready_i off the imem address path.

Pop:
- if_valid_o = (count != 0). Head fields are driven from registers.
- A transfer is if_valid_o && if_ready_i; it advances the head.
- Push and pop in the same cycle leave count unchanged.
- Sustained ready = 1 gives 1 instruction/cycle after a 1-cycle fill latency (PC at cycle N appears on if_* at cycle N+1).

Redirect (highest priority):
- count <= 0; pc_q <= redirect_pc_i; no push.
- Any head transfer in the same cycle is void; decode must kill it.
- Redirect is legal in every state. In IDLE it updates pc_q and stays in IDLE.
- The target is not checked until it is next used in RUN.

IDLE/FAULT:
- The buffer continues to drain normally; no pushes occur.

Decomposition:
rv_fetch_pkg:
- fetch_state_e enum {IDLE, RUN, FAULT}.
- fetch_entry_t struct {pc[31:0], instr[31:0]}.
- Constant INSTR_BYTES = 4.

Sub-module rv_fetch_buf:
- 2-entry FIFO of fetch_entry_t.
- Ports: push, pop, flush, full, empty, head.
- Registered count, with flush priority over push and pop.

rv_fetch keeps the PC, the FSM and the fault logic.

Test Plan:
- Reset then fetch_en_i = 1, ready held 1, imem returns 32'h1000_0000 + index -> imem_addr_o = 0, 1, 2, ...; if_pc_o = 0, 4, 8, ... one per cycle, starting the cycle after fetch_en_i.
- ready = 0 for 5 cycles from PC 0 -> count saturates at 2 holding PC 0 and 4, and imem_addr_o holds 2. On ready = 1: PC 0, 4, 8 delivered in order, with no duplicates or drops.
- Buffer full with PC 8, 12 and redirect_i = 1 with redirect_pc_i = 32'h40 -> next cycle if_valid_o = 0 and imem_addr_o = 16. The cycle after, if_pc_o = 32'h40.
- redirect_pc_i = 32'h42 -> FAULT next cycle, fault_pc_o = 32'h42, no further pushes. Redirect to 32'h80 -> RUN, and 32'h80 is fetched.
- pc_q reaches 32'hFFC with IMEM_DEPTH = 1024 -> 32'hFFC delivered, 32'h1000 faults with fault_pc_o = 32'h1000. Separately, RESET_PC = 32'hFFFF_FFFC with IMEM_DEPTH = 2^30 -> wraps to 0.
- reset_n asserted asynchronously mid-stream with 2 entries buffered -> if_valid_o drops immediately and pc_q = RESET_PC. fetch_en_i = 0 during RUN -> at most one more push, then the buffer drains.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the instruction fetch stage
//   fetch_state_e : fetch FSM states (IDLE, RUN, FAULT)
//   fetch_entry_t : one fetch buffer entry {pc, instr}
//   INSTR_BYTES   : byte stride between consecutive instructions
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/rv_fetch_buf.sv
// rtl/rv_fetch_buf.sv - 2-entry FIFO holding fetched {pc, instr} pairs
//   clk, reset_n : clock, asynchronous active-low reset
//   push, tail   : write tail into the FIFO (ignored when full)
//   pop          : advance the head (ignored when empty)
//   flush        : discard all entries; wins over push and pop
//   full, empty  : occupancy flags from the registered count
//   head         : oldest entry, driven from registers
module rv_fetch_buf
  import rv_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t tail,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  logic [1:0]   count_q;
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  fetch_entry_t mem_q [2];

  logic do_push;
  logic do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (flush) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= tail;
  end

endmodule

// File: rtl/rv_fetch.sv
// rtl/rv_fetch.sv - instruction fetch stage: PC, fetch FSM, fault detection, fetch buffer
//   clk, reset_n          : clock, asynchronous active-low reset
//   fetch_en_i            : allow new fetches
//   imem_addr_o           : word index into imem ({2'b00, pc_q[31:2]})
//   imem_instr_i          : combinational imem read data for imem_addr_o
//   redirect_i/_pc_i      : taken branch/jump, flushes buffer and loads PC
//   if_valid_o/if_ready_i : handshake to decode
//   if_pc_o, if_instr_o   : head entry of the fetch buffer
//   fault_o, fault_pc_o   : fetch halted on fault, and the offending PC
module rv_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o
);

  // 33 bits so a depth of 2^32 words would still compare correctly.
  localparam logic [32:0] DEPTH_W = 33'(IMEM_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  fault_pc_q;

  logic         fault_cond;
  logic         fault_fire;
  logic         push;
  logic         pop;
  logic         buf_full;
  logic         buf_empty;
  fetch_entry_t buf_tail;
  fetch_entry_t buf_head;

  assign imem_addr_o = {2'b00, pc_q[31:2]};

  assign fault_cond = (pc_q[1:0] != 2'b00) || ({3'b000, pc_q[31:2]} >= DEPTH_W);

  assign if_valid_o = !buf_empty;
  assign if_pc_o    = buf_head.pc;
  assign if_instr_o = buf_head.instr;
  assign fault_pc_o = fault_pc_q;

  // A pop during redirect is harmless: the flush discards the buffer anyway.
  assign pop = if_valid_o && if_ready_i;

  assign buf_tail.pc    = pc_q;
  assign buf_tail.instr = imem_instr_i;

  always_comb begin
    state_d    = state_q;
    fault_fire = 1'b0;
    push       = 1'b0;
    fault_o    = 1'b0;

    case (state_q)
      IDLE: begin
        // A redirect in IDLE only moves the PC; fetching resumes a cycle later.
        if (fetch_en_i && !redirect_i) state_d = RUN;
      end
      RUN: begin
        if (fetch_en_i && !redirect_i) begin
          if (fault_cond) begin
            fault_fire = 1'b1;
          end else if (!buf_full) begin
            // Uses the pre-pop full flag so if_ready_i never reaches the PC/imem path.
            push = 1'b1;
          end
        end
        if (!fetch_en_i)     state_d = IDLE;
        else if (fault_fire) state_d = FAULT;
      end
      FAULT: begin
        fault_o = 1'b1;
        if (redirect_i) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_i) begin
      pc_q <= redirect_pc_i;
    end else if (push) begin
      pc_q <= pc_q + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_pc_q <= 32'h0000_0000;
    end else if (fault_fire) begin
      fault_pc_q <= pc_q;
    end
  end

  rv_fetch_buf u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .tail    (buf_tail),
    .pop     (pop),
    .flush   (redirect_i),
    .full    (buf_full),
    .empty   (buf_empty),
    .head    (buf_head)
  );

endmodule

// File: tb/tb_rv_fetch.sv
// tb/tb_rv_fetch.sv - directed self-checking bench for rv_fetch
module tb_rv_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fault;
  logic [31:0] fault_pc;

  logic        w_fetch_en;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_instr;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;
  logic        w_fault;
  logic [31:0] w_fault_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_instr   = 32'h1000_0000 + imem_addr;
  assign w_imem_instr = 32'h2000_0000 + w_imem_addr;

  rv_fetch #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(1024)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_en_i    (fetch_en),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .if_valid_o    (if_valid),
    .if_ready_i    (if_ready),
    .if_pc_o       (if_pc),
    .if_instr_o    (if_instr),
    .fault_o       (fault),
    .fault_pc_o    (fault_pc)
  );

  rv_fetch #(.RESET_PC(32'hFFFF_FFFC), .IMEM_DEPTH(32'h4000_0000)) dut_w (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_en_i    (w_fetch_en),
    .imem_addr_o   (w_imem_addr),
    .imem_instr_i  (w_imem_instr),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0000_0000),
    .if_valid_o    (w_if_valid),
    .if_ready_i    (1'b1),
    .if_pc_o       (w_if_pc),
    .if_instr_o    (w_if_instr),
    .fault_o       (w_fault),
    .fault_pc_o    (w_fault_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_cmp++; if (fault_pc !== 32'h0) begin n_bad++; $display("FAIL reset_fault_pc: got %h want 0", fault_pc); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_cmp++; if (w_imem_addr !== 32'h3FFF_FFFF) begin n_bad++; $display("FAIL reset_w_addr: got %h want 3fffffff", w_imem_addr); end
    reset_n = 1'b1;
    step();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", if_valid); end
  endtask

  task automatic test_wrap();
    w_fetch_en = 1'b1;
    step();
    n_cmp++; if (w_if_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_fill: got %b want 0", w_if_valid); end
    step();
    n_cmp++; if (w_if_valid !== 1'b1 || w_if_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top: got %b/%h want 1/fffffffc", w_if_valid, w_if_pc); end
    n_cmp++; if (w_imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", w_imem_addr); end
    step();
    n_cmp++; if (w_if_pc !== 32'h0 || w_if_instr !== 32'h2000_0000) begin n_bad++; $display("FAIL wrap_zero: got %h/%h want 0/20000000", w_if_pc, w_if_instr); end
    n_cmp++; if (w_fault !== 1'b0) begin n_bad++; $display("FAIL wrap_fault: got %b want 0", w_fault); end
  endtask

  task automatic test_stream();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    step();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL stream_fill: got %b want 0", if_valid); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== 32'h1000_0000 + 32'(k) || imem_addr !== 32'(k + 1)) begin
        n_bad++;
        $display("FAIL stream_%0d: got v=%b pc=%h instr=%h addr=%h want pc=%h addr=%h", k, if_valid, if_pc, if_instr, imem_addr, 32'(4 * k), 32'(k + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    redirect = 1'b1; redirect_pc = 32'h0; if_ready = 1'b0;
    step();
    redirect = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL bp_restart: got %b/%h want 0/0", if_valid, imem_addr); end
    repeat (5) step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 32'h2) begin n_bad++; $display("FAIL bp_hold: got %b/%h/%h want 1/0/2", if_valid, if_pc, imem_addr); end
    if_ready = 1'b1;
    step();
    n_cmp++; if (if_pc !== 32'h4 || imem_addr !== 32'h2) begin n_bad++; $display("FAIL bp_drain4: got %h/%h want 4/2", if_pc, imem_addr); end
    step();
    n_cmp++; if (if_pc !== 32'h8) begin n_bad++; $display("FAIL bp_drain8: got %h want 8", if_pc); end
    step();
    n_cmp++; if (if_pc !== 32'hC) begin n_bad++; $display("FAIL bp_drain12: got %h want c", if_pc); end
  endtask

  task automatic test_redirect();
    if_ready = 1'b0;
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hC || imem_addr !== 32'h5) begin n_bad++; $display("FAIL rd_full: got %b/%h/%h want 1/c/5", if_valid, if_pc, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd16) begin n_bad++; $display("FAIL rd_flush: got %b/%h want 0/10", if_valid, imem_addr); end
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h1000_0010) begin n_bad++; $display("FAIL rd_target: got %b/%h/%h want 1/40/10000010", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_fault();
    if_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    n_cmp++; if (fault !== 1'b0 || if_valid !== 1'b0) begin n_bad++; $display("FAIL flt_pre: got %b/%b want 0/0", fault, if_valid); end
    step();
    n_cmp++; if (fault !== 1'b1 || fault_pc !== 32'h42) begin n_bad++; $display("FAIL flt_enter: got %b/%h want 1/42", fault, fault_pc); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL flt_nopush: got %b want 0", if_valid); end
    step();
    n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h10) begin n_bad++; $display("FAIL flt_sticky: got %b/%b/%h want 1/0/10", fault, if_valid, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    n_cmp++; if (fault !== 1'b0 || fault_pc !== 32'h42) begin n_bad++; $display("FAIL flt_exit: got %b/%h want 0/42", fault, fault_pc); end
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h80) begin n_bad++; $display("FAIL flt_resume: got %b/%h want 1/80", if_valid, if_pc); end
  endtask

  task automatic test_range();
    redirect = 1'b1; redirect_pc = 32'hFF8;
    step();
    redirect = 1'b0;
    step();
    n_cmp++; if (if_pc !== 32'hFF8) begin n_bad++; $display("FAIL rng_ff8: got %h want ff8", if_pc); end
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hFFC || fault !== 1'b0) begin n_bad++; $display("FAIL rng_ffc: got %b/%h/%b want 1/ffc/0", if_valid, if_pc, fault); end
    step();
    n_cmp++; if (fault !== 1'b1 || fault_pc !== 32'h1000 || if_valid !== 1'b0) begin n_bad++; $display("FAIL rng_fault: got %b/%h/%b want 1/1000/0", fault, fault_pc, if_valid); end
  endtask

  task automatic test_async_reset();
    redirect = 1'b1; redirect_pc = 32'h0; if_ready = 1'b0;
    step();
    redirect = 1'b0;
    step();
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 32'h2) begin n_bad++; $display("FAIL ar_full: got %b/%h/%h want 1/0/2", if_valid, if_pc, imem_addr); end
    #3 reset_n = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL ar_drop: got %b/%h want 0/0", if_valid, imem_addr); end
    n_cmp++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin n_bad++; $display("FAIL ar_fault: got %b/%h want 0/0", fault, fault_pc); end
    #2 reset_n = 1'b1;
    step();
  endtask

  task automatic test_fetch_disable();
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_bad++; $display("FAIL dis_first: got %b/%h want 1/0", if_valid, if_pc); end
    fetch_en = 1'b0;
    step();
    n_cmp++; if (if_pc !== 32'h0 || imem_addr !== 32'h1) begin n_bad++; $display("FAIL dis_stop: got %h/%h want 0/1", if_pc, imem_addr); end
    if_ready = 1'b1;
    step();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL dis_drain: got %b want 0", if_valid); end
    step();
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h1) begin n_bad++; $display("FAIL dis_idle: got %b/%h want 0/1", if_valid, imem_addr); end
  endtask

  initial begin
    reset_n     = 1'b0;
    fetch_en    = 1'b0;
    if_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    w_fetch_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_wrap();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_range();
    test_async_reset();
    test_fetch_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
